// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the register file write port.
// The master side is the requester/observer; the slave side is the arbiter.
interface rf_wb_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic              s0_valid;
  logic              s0_ready;
  logic [AW-1:0]     s0_addr;
  logic [DW-1:0]     s0_data;
  logic              s1_valid;
  logic              s1_ready;
  logic [AW-1:0]     s1_addr;
  logic [DW-1:0]     s1_data;
  logic              we3;
  logic [AW-1:0]     a3;
  logic [DW-1:0]     wd3;
  logic [2**AW-1:0]  pend;
  logic              idle;

  modport master (
    output s0_valid, s0_addr, s0_data,
    output s1_valid, s1_addr, s1_data,
    input  s0_ready, s1_ready,
    input  we3, a3, wd3, pend, idle
  );

  modport slave (
    input  s0_valid, s0_addr, s0_data,
    input  s1_valid, s1_addr, s1_data,
    output s0_ready, s1_ready,
    output we3, a3, wd3, pend, idle
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-port writeback arbiter with one-entry buffers and a registered register-file write stage.
// Define RF_WB_ARB_RR_EN for round-robin tie breaking; otherwise port 0 has fixed priority.
module rf_wb_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  rf_wb_arbiter_if.slave     bus
);
  localparam int NR = 1 << AW;

  function automatic logic [NR-1:0] f_dec(input logic [AW-1:0] a);
    f_dec = {{(NR-1){1'b0}}, 1'b1} << a;
  endfunction

  logic          r_full0, r_full1;
  logic [AW-1:0] r_addr0, r_addr1;
  logic [DW-1:0] r_data0, r_data1;
  logic          r_we3;
  logic [AW-1:0] r_a3;
  logic [DW-1:0] r_wd3;
  logic [NR-1:0] r_pend;
  logic          r_idle;
`ifdef RF_WB_ARB_RR_EN
  logic          r_last1;
`endif

  logic          w_grant0, w_grant1;
  logic          w_ready0, w_ready1;
  logic          w_fill0, w_fill1;
  logic          w_full0_n, w_full1_n;
  logic [AW-1:0] w_addr0_n, w_addr1_n;
  logic [DW-1:0] w_data0_n, w_data1_n;
  logic          w_we3_n;
  logic [AW-1:0] w_a3_n;
  logic [DW-1:0] w_wd3_n;
  logic [NR-1:0] w_pend_n;
  logic          w_idle_n;

  // Grant selection over the buffer full flags only, so ready never sees valid.
  always_comb begin
`ifdef RF_WB_ARB_RR_EN
    w_grant0 = r_full0 & (!r_full1 | r_last1);
`else
    w_grant0 = r_full0;
`endif
    w_grant1  = r_full1 & !w_grant0;
    w_ready0  = !r_full0 | w_grant0;
    w_ready1  = !r_full1 | w_grant1;
    // Writes to register 0 complete the handshake but never occupy a buffer.
    w_fill0   = bus.s0_valid & w_ready0 & (bus.s0_addr != {AW{1'b0}});
    w_fill1   = bus.s1_valid & w_ready1 & (bus.s1_addr != {AW{1'b0}});
  end

  // Next-state for both holding buffers.
  always_comb begin
    w_full0_n = r_full0;
    w_addr0_n = r_addr0;
    w_data0_n = r_data0;
    w_full1_n = r_full1;
    w_addr1_n = r_addr1;
    w_data1_n = r_data1;
    if (w_fill0) begin
      w_full0_n = 1'b1;
      w_addr0_n = bus.s0_addr;
      w_data0_n = bus.s0_data;
    end else if (w_grant0) begin
      w_full0_n = 1'b0;
    end else begin
      w_full0_n = r_full0;
    end
    if (w_fill1) begin
      w_full1_n = 1'b1;
      w_addr1_n = bus.s1_addr;
      w_data1_n = bus.s1_data;
    end else if (w_grant1) begin
      w_full1_n = 1'b0;
    end else begin
      w_full1_n = r_full1;
    end
  end

  // Next-state for the output stage plus the registered pend/idle views of it.
  always_comb begin
    w_we3_n = w_grant0 | w_grant1;
    w_a3_n  = r_a3;
    w_wd3_n = r_wd3;
    if (w_grant0) begin
      w_a3_n  = r_addr0;
      w_wd3_n = r_data0;
    end else if (w_grant1) begin
      w_a3_n  = r_addr1;
      w_wd3_n = r_data1;
    end else begin
      w_a3_n  = r_a3;
      w_wd3_n = r_wd3;
    end
    w_pend_n = {NR{1'b0}};
    if (w_full0_n) begin
      w_pend_n = w_pend_n | f_dec(w_addr0_n);
    end else begin
      w_pend_n = w_pend_n;
    end
    if (w_full1_n) begin
      w_pend_n = w_pend_n | f_dec(w_addr1_n);
    end else begin
      w_pend_n = w_pend_n;
    end
    if (w_we3_n) begin
      w_pend_n = w_pend_n | f_dec(w_a3_n);
    end else begin
      w_pend_n = w_pend_n;
    end
    w_idle_n = !w_full0_n & !w_full1_n & !w_we3_n;
  end

  // State registers; reset drops every buffered and staged write immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full0 <= 1'b0;
      r_addr0 <= {AW{1'b0}};
      r_data0 <= {DW{1'b0}};
      r_full1 <= 1'b0;
      r_addr1 <= {AW{1'b0}};
      r_data1 <= {DW{1'b0}};
      r_we3   <= 1'b0;
      r_a3    <= {AW{1'b0}};
      r_wd3   <= {DW{1'b0}};
      r_pend  <= {NR{1'b0}};
      r_idle  <= 1'b1;
    end else begin
      r_full0 <= w_full0_n;
      r_addr0 <= w_addr0_n;
      r_data0 <= w_data0_n;
      r_full1 <= w_full1_n;
      r_addr1 <= w_addr1_n;
      r_data1 <= w_data1_n;
      r_we3   <= w_we3_n;
      r_a3    <= w_a3_n;
      r_wd3   <= w_wd3_n;
      r_pend  <= w_pend_n;
      r_idle  <= w_idle_n;
    end
  end

`ifdef RF_WB_ARB_RR_EN
  // Round-robin pointer; starts as "port 1 last" so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last1 <= 1'b1;
    end else if (w_grant0) begin
      r_last1 <= 1'b0;
    end else if (w_grant1) begin
      r_last1 <= 1'b1;
    end else begin
      r_last1 <= r_last1;
    end
  end
`endif

  assign bus.s0_ready = w_ready0;
  assign bus.s1_ready = w_ready1;
  assign bus.we3      = r_we3;
  assign bus.a3       = r_a3;
  assign bus.wd3      = r_wd3;
  assign bus.pend     = r_pend;
  assign bus.idle     = r_idle;
endmodule
